// File: rtl/gesture_decode.sv
// Gesture-flag byte decoder: priority-encodes each accepted I2C flag byte,
// pulses an event, counts gestures and holds an LED pattern for HOLD_CYCLES.
module gesture_decode #(
  parameter int HOLD_CYCLES = 25_000_000,
  parameter int CNT_W       = 25
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       rd_valid,
  input  logic [7:0] rd_data,
  output logic       gest_valid,
  output logic [3:0] gest_code,
  output logic [3:0] led,
  output logic       busy,
  output logic [7:0] gest_cnt
);

  typedef enum logic {IDLE, SHOW} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_hold;
  logic             r_gest_valid;
  logic [3:0]       r_gest_code;
  logic [3:0]       r_led;
  logic             r_busy;
  logic [7:0]       r_gest_cnt;

  logic       w_accept;
  logic       w_term;
  logic [3:0] w_code;
  logic [3:0] w_led;

  assign w_accept = rd_valid && (rd_data != 8'd0);
  assign w_term   = (r_hold == CNT_W'(HOLD_CYCLES - 1));

  // Lowest set bit wins: scan from the top so the last hit is the lowest.
  always_comb begin
    w_code = 4'd0;
    for (int i = 7; i >= 0; i--)
      if (rd_data[i]) w_code = 4'(i + 1);
  end

  always_comb begin
    case (w_code)
      4'd1:    w_led = 4'b0001;
      4'd2:    w_led = 4'b0010;
      4'd3:    w_led = 4'b0100;
      4'd4:    w_led = 4'b1000;
      4'd5:    w_led = 4'b0011;
      4'd6:    w_led = 4'b1100;
      4'd7:    w_led = 4'b0101;
      4'd8:    w_led = 4'b1010;
      default: w_led = 4'b0000;
    endcase
  end

  // A new acceptance always takes priority over terminal count.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state      <= IDLE;
      r_hold       <= '0;
      r_gest_valid <= 1'b0;
      r_gest_code  <= 4'd0;
      r_led        <= 4'd0;
      r_busy       <= 1'b0;
      r_gest_cnt   <= 8'd0;
    end else begin
      r_gest_valid <= 1'b0;
      if (w_accept) begin
        r_state      <= SHOW;
        r_hold       <= '0;
        r_gest_valid <= 1'b1;
        r_gest_code  <= w_code;
        r_led        <= w_led;
        r_busy       <= 1'b1;
        r_gest_cnt   <= r_gest_cnt + 8'd1;
      end else if (r_state == SHOW) begin
        if (w_term) begin
          r_state <= IDLE;
          r_hold  <= '0;
          r_led   <= 4'd0;
          r_busy  <= 1'b0;
        end else begin
          r_hold  <= r_hold + 1'b1;
        end
      end
    end
  end

  assign gest_valid = r_gest_valid;
  assign gest_code  = r_gest_code;
  assign led        = r_led;
  assign busy       = r_busy;
  assign gest_cnt   = r_gest_cnt;

endmodule

// File: tb/tb_gesture_decode.sv
// Scoreboarded random/directed bench for gesture_decode with a time-based
// reference model (edge of last acceptance, running count, last code).
module tb_gesture_decode;
  localparam int H = 8;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b0;
  logic       rd_valid = 1'b0;
  logic [7:0] rd_data = 8'd0;
  logic       gest_valid;
  logic [3:0] gest_code;
  logic [3:0] led;
  logic       busy;
  logic [7:0] gest_cnt;

  gesture_decode #(.HOLD_CYCLES(H), .CNT_W(4)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .rd_valid(rd_valid), .rd_data(rd_data),
    .gest_valid(gest_valid), .gest_code(gest_code), .led(led), .busy(busy),
    .gest_cnt(gest_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [3:0] code;
    logic [3:0] led;
    logic [7:0] cnt;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  int         ecnt = 0;
  bit         chk_en = 0;
  bit         m_have = 0;
  int         m_edge = 0;
  logic [3:0] m_code = 0;
  logic [7:0] m_cnt = 0;
  logic [3:0] ledmap [9] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'h5, 4'hA};

  always @(posedge sys_clk) ecnt <= ecnt + 1;

  function automatic logic [3:0] prio(input logic [7:0] d);
    for (int i = 0; i < 8; i++) if (d[i]) return 4'(i + 1);
    return 4'd0;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, ecnt, act, exp);
    end
  endtask

  // One clock of stimulus; the model is updated just after the edge it describes.
  task automatic send(input bit v, input logic [7:0] d);
    rd_valid = v;
    rd_data  = d;
    @(posedge sys_clk);
    #1;
    if (v && d != 0) begin
      m_have = 1;
      m_edge = ecnt;
      m_code = prio(d);
      m_cnt  = m_cnt + 8'd1;
      q.push_back('{code: m_code, led: ledmap[m_code], cnt: m_cnt});
    end
    rd_valid = 1'b0;
    rd_data  = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) send(1'b0, 8'($urandom));
  endtask

  task automatic do_reset(input int n);
    sys_rst = 1'b1;
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
    m_have = 0; m_code = 0; m_cnt = 0;
    q.delete();
    chk_en  = 1;
    sys_rst = 1'b0;
  endtask

  // Per-cycle model comparison plus scoreboard pop on each event pulse.
  always @(negedge sys_clk) begin
    if (chk_en && !sys_rst) begin
      automatic bit       e_busy = m_have && (ecnt - m_edge) < H;
      automatic bit       e_pulse = m_have && (ecnt == m_edge);
      automatic logic [3:0] e_led = e_busy ? ledmap[m_code] : 4'd0;
      chk("busy", 8'(busy), 8'(e_busy));
      chk("led", 8'(led), 8'(e_led));
      chk("gest_valid", 8'(gest_valid), 8'(e_pulse));
      chk("gest_code", 8'(gest_code), 8'(m_code));
      chk("gest_cnt", gest_cnt, m_cnt);
      if (gest_valid === 1'b1) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_unexpected at edge %0d: pulse with empty scoreboard", ecnt);
        end else begin
          automatic exp_t e = q.pop_front();
          chk("sb_code", 8'(gest_code), 8'(e.code));
          chk("sb_led", 8'(led), 8'(e.led));
          chk("sb_cnt", gest_cnt, e.cnt);
        end
      end
    end
  end

  initial begin
    logic [7:0] base;
    do_reset(3);
    idle(20);
    // single gesture, full hold and retained code
    send(1, 8'h01); idle(12);
    // priority and ignored zero byte
    send(1, 8'hC4); send(1, 8'h00); idle(10);
    // retrigger five cycles after the first acceptance
    send(1, 8'h80); idle(4); send(1, 8'h10); idle(12);
    // acceptance exactly on terminal count
    send(1, 8'h02); idle(H - 1); send(1, 8'h08); idle(12);
    // back-to-back and random traffic
    for (int i = 0; i < 400; i++) begin
      automatic int r = $urandom_range(0, 9);
      if (r < 3)      send(1, 8'($urandom));
      else if (r < 4) send(1, 8'h00);
      else if (r < 5) send(1, 8'(1 << $urandom_range(0, 7)));
      else            send(0, 8'($urandom));
    end
    idle(12);
    // 256 acceptances return the count to its start value
    base = m_cnt;
    for (int i = 0; i < 256; i++) send(1, 8'($urandom_range(1, 255)));
    checks++;
    if (gest_cnt !== base) begin
      errors++;
      $display("FAIL wrap: got %0d expected %0d", gest_cnt, base);
    end
    // reset in the middle of a hold
    idle(2);
    do_reset(1);
    idle(15);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expected pulses never seen", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
